instr_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the processor datapath: fetch, decode and execute of LW/SW/BEQ.

---
 rtl/instr_seq_ctrl_if.sv | 42 ++++
 rtl/instr_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_seq_ctrl_if.sv
// Purpose : Bundles the sequencer's RAM handshake and register-file ports.
//           The sequencer uses the master modport. The RAM and register-file
//           side uses the slave modport.
// Signals : mem_req/mem_we/mem_addr/mem_wdata  sequencer -> RAM
//           mem_rdata/mem_ready                RAM -> sequencer
//           rf_ra1/rf_ra2/rf_we/rf_wa/rf_wdata sequencer -> register file
//           rf_rd1/rf_rd2                      register file -> sequencer (combinational read)
interface instr_seq_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [RF_AW-1:0]  rf_ra1;
    logic [RF_AW-1:0]  rf_ra2;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_wa;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output rf_ra1, rf_ra2,
        input  rf_rd1, rf_rd2,
        output rf_we, rf_wa, rf_wdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  rf_ra1, rf_ra2,
        output rf_rd1, rf_rd2,
        input  rf_we, rf_wa, rf_wdata
    );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Purpose : Multi-cycle fetch/decode/execute sequencer for NOP/LW/SW/BEQ/HALT.
//           It owns the PC and time-shares one single-port RAM between
//           instruction fetch and data access.
// Ports   : clk, rst_n (synchronous, active low), start_i (begin/resume pulse)
//           bus       RAM handshake and register-file ports (master modport)
//           pc_o      program counter
//           ir_o      current instruction
//           busy_o    high while not IDLE/HALTED
//           halted_o  high after HALT
//           illegal_o sticky undefined-opcode flag
//           retired_o instruction counter
// All outputs decode from registers only, so nothing depends combinationally
// on mem_ready.
module instr_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    instr_seq_ctrl_if.master  bus,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       ir_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              illegal_o,
    output logic [31:0]       retired_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       retired_q, retired_d;

    logic [2:0]        opcode_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0] imm_addr_s;

    assign opcode_s   = ir_q[31:29];
    // Addition wraps modulo 2^ADDR_W.
    assign pc_inc_s   = pc_q + PC_ONE;
    // The sign-extended offset added modulo 2^ADDR_W gives forward and backward branches.
    assign br_off_s   = ADDR_W'($signed(ir_q[15:0]));
    assign imm_addr_s = ADDR_W'(ir_q[15:0]);

    // Next-state, PC, instruction and flag update logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        data_d    = data_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata[31:0];
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Operands are captured here, so a later WB to the same register cannot disturb them.
                op1_d   = bus.rf_rd1;
                op2_d   = bus.rf_rd2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode_s)
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        if (op1_q == op2_q) begin
                            pc_d = pc_inc_s + br_off_s;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    OP_HALT: begin
                        halted_d  = 1'b1;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_HALTED;
                    end
                    OP_NOP: begin
                        pc_d      = pc_inc_s;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        pc_d      = pc_inc_s;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (opcode_s == OP_LW) begin
                        data_d  = bus.mem_rdata;
                        state_d = S_WB;
                    end else begin
                        pc_d      = pc_inc_s;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                pc_d      = pc_inc_s;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALTED: begin
                if (start_i) begin
                    pc_d      = '0;
                    halted_d  = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= 32'd0;
            op1_q     <= '0;
            op2_q     <= '0;
            data_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            data_q    <= data_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // The request fields depend only on state and registers, so they hold steady across wait states.
    assign bus.mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign bus.mem_we    = (state_q == S_MEM) && (opcode_s == OP_SW);
    assign bus.mem_addr  = (state_q == S_MEM) ? imm_addr_s : pc_q;
    assign bus.mem_wdata = op1_q;
    assign bus.rf_ra1    = RF_AW'(ir_q[28:24]);
    assign bus.rf_ra2    = RF_AW'(ir_q[23:19]);
    assign bus.rf_wa     = RF_AW'(ir_q[28:24]);
    assign bus.rf_we     = (state_q == S_WB);
    assign bus.rf_wdata  = data_q;

    assign pc_o      = pc_q;
    assign ir_o      = ir_q;
    assign busy_o    = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted_o  = halted_q;
    assign illegal_o = illegal_q;
    assign retired_o = retired_q;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
module tb_instr_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        busy, halted, illegal;
    logic [31:0] retired;

    instr_seq_ctrl_if #(.ADDR_W(16), .DATA_W(32), .RF_AW(5)) bus ();

    instr_seq_ctrl #(.ADDR_W(16), .DATA_W(32), .RF_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .bus(bus),
        .pc_o(pc), .ir_o(ir), .busy_o(busy), .halted_o(halted),
        .illegal_o(illegal), .retired_o(retired)
    );

    always #5 clk = ~clk;

    // Environment: RAM and register file as seen by the DUT.
    logic [31:0] mem [0:65535];
    logic [31:0] rf  [0:31];
    assign bus.rf_rd1 = rf[bus.rf_ra1];
    assign bus.rf_rd2 = rf[bus.rf_ra2];

    // ISA-level reference model: one call executes one whole instruction.
    logic [31:0] m_mem [0:65535];
    logic [31:0] m_rf  [0:31];
    logic [15:0] m_pc;
    bit          m_ill, m_hlt;
    logic [31:0] m_ret;
    int          m_wr;

    int errors = 0, checks = 0, cyc = 0;
    int wait_left = 0, rfwe_cnt = 0, wr_cnt = 0, last_ret_cyc = 0, lat_meas = 0;
    bit rnd_mode = 0, stall_writes = 0, model_on = 0;
    bit pend = 0;
    logic [15:0] pend_addr;
    logic        pend_we;
    logic [31:0] pend_wdata;
    logic [31:0] ret_prev = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] imm);
        return {op, a, b, 3'b000, imm};
    endfunction

    task automatic model_exec();
        logic [31:0] ins;
        logic [4:0]  a, b;
        logic [15:0] imm;
        ins = m_mem[m_pc];
        a   = ins[28:24];
        b   = ins[23:19];
        imm = ins[15:0];
        case (ins[31:29])
            3'd0: m_pc = m_pc + 16'd1;
            3'd1: begin m_rf[a] = m_mem[imm]; m_pc = m_pc + 16'd1; end
            3'd2: begin m_mem[imm] = m_rf[a]; m_wr++; m_pc = m_pc + 16'd1; end
            3'd3: m_pc = (m_rf[a] == m_rf[b]) ? (m_pc + 16'd1 + imm) : (m_pc + 16'd1);
            3'd7: m_hlt = 1'b1;
            default: begin m_ill = 1'b1; m_pc = m_pc + 16'd1; end
        endcase
        m_ret = m_ret + 32'd1;
    endtask

    function automatic bit rf_eq();
        for (int i = 0; i < 32; i++) if (rf[i] !== m_rf[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit mem_eq();
        for (int i = 0; i < 128; i++) if (mem[i] !== m_mem[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: observe at the falling edge, respond as RAM/RF, then run the model on retirement.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend && rst_n) begin
            chk("hold_req", bus.mem_req, 64'd1);
            chk("hold_fields", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, {pend_addr, pend_we, pend_wdata});
        end
        if (bus.rf_we === 1'b1) begin
            rf[bus.rf_wa] = bus.rf_wdata;
            rfwe_cnt++;
        end
        if (bus.mem_req === 1'b1) begin
            if (wait_left > 0 || (stall_writes && bus.mem_we)) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom();
                if (wait_left > 0) wait_left--;
            end else begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we) begin
                    mem[bus.mem_addr] = bus.mem_wdata;
                    wr_cnt++;
                end
                wait_left = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end
        end else begin
            bus.mem_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom();
        end
        pend       = (bus.mem_req === 1'b1) && !bus.mem_ready;
        pend_addr  = bus.mem_addr;
        pend_we    = bus.mem_we;
        pend_wdata = bus.mem_wdata;
        if (retired !== ret_prev && rst_n) begin
            lat_meas     = cyc - last_ret_cyc;
            last_ret_cyc = cyc;
            if (model_on) begin
                chk("retire_step", retired, ret_prev + 32'd1);
                model_exec();
                chk("m_pc", pc, m_pc);
                chk("m_illegal", illegal, m_ill);
                chk("m_halted", halted, m_hlt);
                chk("m_busy", busy, !m_hlt);
                chk("m_retired", retired, m_ret);
                chk("m_rf", rf_eq(), 64'd1);
                chk("m_mem", mem_eq(), 64'd1);
                chk("m_writes", wr_cnt, m_wr);
            end
        end
        ret_prev = retired;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        start_i  = 1'b0;
        model_on = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        pend      = 1'b0;
        rfwe_cnt  = 0;
        wr_cnt    = 0;
        wait_left = 0;
        ret_prev  = retired;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 32'd0;
            m_mem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        last_ret_cyc = cyc;
    endtask

    typedef struct {
        logic [15:0] spc;
        logic [31:0] ins;
        logic [31:0] va, vb, mval;
        int          lat;
        logic [15:0] epc;
        bit          ill, hlt;
        int          rfwe, wr;
        logic [4:0]  rf_idx;
        logic [31:0] rf_val;
        logic [15:0] maddr;
        logic [31:0] mexp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        logic [31:0] ins;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        rst_n   = 1'b0;
        start_i = 1'b0;

        //               spc       ins                                va            vb            mval          lat epc       ill hlt rfwe wr rf_idx rf_val        maddr     mexp
        vecs[0]  = '{16'd0,    enc(3'd1, 5'd3, 5'd0, 16'h0010), 32'd0,        32'd0,        32'hDEADBEEF, 5, 16'd1,    0, 0, 1, 0, 5'd3, 32'hDEADBEEF, 16'h0010, 32'hDEADBEEF};
        vecs[1]  = '{16'd0,    enc(3'd2, 5'd2, 5'd0, 16'h0020), 32'h12345678, 32'd0,        32'd0,        4, 16'd1,    0, 0, 0, 1, 5'd2, 32'h12345678, 16'h0020, 32'h12345678};
        vecs[2]  = '{16'd5,    enc(3'd3, 5'd1, 5'd2, 16'h0004), 32'h0000A5A5, 32'h0000A5A5, 32'd0,        3, 16'd10,   0, 0, 0, 0, 5'd1, 32'h0000A5A5, 16'h0030, 32'd0};
        vecs[3]  = '{16'd5,    enc(3'd3, 5'd1, 5'd2, 16'h0004), 32'd1,        32'd2,        32'd0,        3, 16'd6,    0, 0, 0, 0, 5'd1, 32'd1,        16'h0030, 32'd0};
        vecs[4]  = '{16'd0,    enc(3'd3, 5'd1, 5'd2, 16'hFFFF), 32'd7,        32'd7,        32'd0,        3, 16'd0,    0, 0, 0, 0, 5'd1, 32'd7,        16'h0030, 32'd0};
        vecs[5]  = '{16'd0,    enc(3'd3, 5'd1, 5'd2, 16'hFFF0), 32'd9,        32'd9,        32'd0,        3, 16'hFFF1, 0, 0, 0, 0, 5'd1, 32'd9,        16'h0030, 32'd0};
        vecs[6]  = '{16'd3,    enc(3'd0, 5'd0, 5'd0, 16'h1234), 32'd0,        32'd0,        32'd0,        3, 16'd4,    0, 0, 0, 0, 5'd0, 32'd0,        16'h0030, 32'd0};
        vecs[7]  = '{16'd0,    enc(3'd6, 5'd1, 5'd0, 16'h0000), 32'd3,        32'd0,        32'd0,        3, 16'd1,    1, 0, 0, 0, 5'd1, 32'd3,        16'h0030, 32'd0};
        vecs[8]  = '{16'd2,    enc(3'd7, 5'd0, 5'd0, 16'h0000), 32'd0,        32'd0,        32'd0,        3, 16'd2,    0, 1, 0, 0, 5'd0, 32'd0,        16'h0030, 32'd0};
        vecs[9]  = '{16'd0,    enc(3'd2, 5'd7, 5'd0, 16'hFFFF), 32'hCAFEF00D, 32'd0,        32'd0,        4, 16'd1,    0, 0, 0, 1, 5'd7, 32'hCAFEF00D, 16'hFFFF, 32'hCAFEF00D};
        vecs[10] = '{16'd1,    enc(3'd4, 5'd2, 5'd0, 16'h0000), 32'd5,        32'd0,        32'd0,        3, 16'd2,    1, 0, 0, 0, 5'd2, 32'd5,        16'h0030, 32'd0};
        vecs[11] = '{16'd0,    enc(3'd1, 5'd4, 5'd4, 16'h0011), 32'h11111111, 32'h11111111, 32'h0BADF00D, 5, 16'd1,    0, 0, 1, 0, 5'd4, 32'h0BADF00D, 16'h0011, 32'h0BADF00D};

        // Reset state.
        reset_dut();
        chk("rst_pc", pc, 64'd0);
        chk("rst_ir", ir, 64'd0);
        chk("rst_retired", retired, 64'd0);
        chk("rst_req", bus.mem_req, 64'd0);
        chk("rst_rf_we", bus.rf_we, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_halted", halted, 64'd0);
        chk("rst_illegal", illegal, 64'd0);

        // Table-driven single-instruction vectors.
        for (int r = 0; r < 12; r++) begin
            reset_dut();
            clear_all();
            rf[vecs[r].ins[23:19]] = vecs[r].vb;
            rf[vecs[r].ins[28:24]] = vecs[r].va;
            mem[vecs[r].spc] = vecs[r].ins;
            if (vecs[r].ins[31:29] == 3'd1) mem[vecs[r].ins[15:0]] = vecs[r].mval;
            do_start();
            n = 0;
            while (retired !== 32'(vecs[r].spc) + 32'd1 && n < 80) begin
                step();
                n++;
            end
            chk($sformatf("row%0d_done", r), retired, 32'(vecs[r].spc) + 32'd1);
            chk($sformatf("row%0d_latency", r), lat_meas, vecs[r].lat);
            chk($sformatf("row%0d_pc", r), pc, vecs[r].epc);
            chk($sformatf("row%0d_illegal", r), illegal, vecs[r].ill);
            chk($sformatf("row%0d_halted", r), halted, vecs[r].hlt);
            chk($sformatf("row%0d_busy", r), busy, !vecs[r].hlt);
            chk($sformatf("row%0d_rf_we_cycles", r), rfwe_cnt, vecs[r].rfwe);
            chk($sformatf("row%0d_writes", r), wr_cnt, vecs[r].wr);
            chk($sformatf("row%0d_rf", r), rf[vecs[r].rf_idx], vecs[r].rf_val);
            chk($sformatf("row%0d_mem", r), mem[vecs[r].maddr], vecs[r].mexp);
        end

        // Fetch held off for 7 cycles: request stable, ir only loads on the ready cycle.
        reset_dut();
        clear_all();
        ins = enc(3'd1, 5'd3, 5'd0, 16'h0010);
        mem[0] = ins;
        mem[16'h0010] = 32'hDEADBEEF;
        wait_left = 7;
        do_start();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            chk("stall_req", bus.mem_req, 64'd1);
            chk("stall_addr", bus.mem_addr, 64'd0);
            chk("stall_we", bus.mem_we, 64'd0);
            chk("stall_ir", ir, 64'd0);
        end
        step();
        chk("ready_cycle_ir_old", ir, 64'd0);
        step();
        chk("ir_loaded", ir, ins);
        n = 0;
        while (retired !== 32'd1 && n < 40) begin step(); n++; end
        chk("stall_pc", pc, 64'd1);
        chk("stall_latency", lat_meas, 64'd12);
        chk("stall_rf3", rf[3], 64'hDEADBEEF);

        // Illegal opcode then HALT, then restart.
        reset_dut();
        clear_all();
        mem[0] = enc(3'd5, 5'd0, 5'd0, 16'h0000);
        mem[1] = enc(3'd7, 5'd0, 5'd0, 16'h0000);
        do_start();
        n = 0;
        while (halted !== 1'b1 && n < 40) begin step(); n++; end
        repeat (3) step();
        chk("halt_illegal", illegal, 64'd1);
        chk("halt_halted", halted, 64'd1);
        chk("halt_busy", busy, 64'd0);
        chk("halt_retired", retired, 64'd2);
        chk("halt_pc", pc, 64'd1);
        chk("halt_no_req", bus.mem_req, 64'd0);
        do_start();
        chk("restart_pc", pc, 64'd0);
        chk("restart_halted", halted, 64'd0);
        chk("restart_illegal", illegal, 64'd0);
        chk("restart_busy", busy, 64'd1);
        chk("restart_fetch_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'd0});

        // Reset while a SW is stalled in its data access.
        reset_dut();
        clear_all();
        rf[2] = 32'h12345678;
        mem[0] = enc(3'd2, 5'd2, 5'd0, 16'h0020);
        stall_writes = 1'b1;
        do_start();
        n = 0;
        while (bus.mem_we !== 1'b1 && n < 20) begin step(); n++; end
        chk("sw_reached_mem", bus.mem_we, 64'd1);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_req", bus.mem_req, 64'd0);
        chk("rst_mid_pc", pc, 64'd0);
        chk("rst_mid_busy", busy, 64'd0);
        rst_n = 1'b1;
        stall_writes = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mid_no_retry", bus.mem_req, 64'd0);
        end
        chk("rst_mid_writes", wr_cnt, 64'd0);
        chk("rst_mid_mem", mem[16'h0020], 64'd0);

        // PC wrap: branch to 0xFFFF, then NOP there wraps to 0.
        reset_dut();
        clear_all();
        mem[0] = enc(3'd3, 5'd0, 5'd0, 16'hFFFE);
        do_start();
        n = 0;
        while (retired !== 32'd1 && n < 40) begin step(); n++; end
        chk("wrap_pc_ffff", pc, 64'hFFFF);
        n = 0;
        while (retired !== 32'd2 && n < 40) begin step(); n++; end
        chk("wrap_pc_0", pc, 64'd0);

        // Random programs with random wait states against the ISA model.
        for (int t = 0; t < 4; t++) begin
            reset_dut();
            clear_all();
            rnd_mode = 1'b1;
            for (int i = 0; i < 47; i++) begin
                int sel;
                logic [15:0] tgt;
                sel = int'($urandom_range(0, 9));
                tgt = 16'($urandom_range(0, 47));
                case (sel)
                    0, 1:    mem[i] = enc(3'd1, 5'($urandom_range(0, 7)), 5'd0, 16'h0040 + 16'($urandom_range(0, 31)));
                    2, 3:    mem[i] = enc(3'd2, 5'($urandom_range(0, 7)), 5'd0, 16'h0040 + 16'($urandom_range(0, 31)));
                    4, 5, 6: mem[i] = enc(3'd3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), tgt - 16'(i + 1));
                    8:       mem[i] = enc(3'($urandom_range(4, 6)), 5'($urandom_range(0, 7)), 5'd0, 16'($urandom));
                    default: mem[i] = enc(3'd0, 5'd0, 5'd0, 16'($urandom));
                endcase
            end
            mem[47] = enc(3'd7, 5'd0, 5'd0, 16'h0000);
            for (int i = 16'h40; i < 16'h60; i++) mem[i] = 32'($urandom_range(0, 2));
            for (int i = 0; i < 8; i++) rf[i] = 32'($urandom_range(0, 2));
            for (int i = 0; i < 128; i++) m_mem[i] = mem[i];
            for (int i = 0; i < 32; i++) m_rf[i] = rf[i];
            m_pc = 16'd0; m_ill = 1'b0; m_hlt = 1'b0; m_ret = 32'd0; m_wr = 0;
            model_on = 1'b1;
            do_start();
            n = 0;
            while (!m_hlt && m_ret < 32'd200 && n < 5000) begin
                start_i = busy && ($urandom_range(0, 7) == 0);
                step();
                n++;
            end
            start_i = 1'b0;
            chk("rnd_within_budget", n < 5000, 64'd1);
            if (m_hlt) chk("rnd_halt_idle", busy, 64'd0);
            model_on = 1'b0;
            rnd_mode = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
